// File: rtl/lfp_pkg.sv
// Shared constants for the log-domain FP multiplier: log/antilog correction bit tables and width helpers.
// Tables are indexed by mantissa width; bit m of each entry is the correction for mantissa value m.
package lfp_pkg;

  localparam int MAN_W_MIN = 2;
  localparam int MAN_W_MAX = 4;

  localparam logic [15:0] VLOG_TAB [MAN_W_MIN:MAN_W_MAX] = '{16'h0000, 16'h003C, 16'h7FFC};
  localparam logic [15:0] VEXP_TAB [MAN_W_MIN:MAN_W_MAX] = '{16'h0000, 16'h0078, 16'h7FFC};

  function automatic int lfp_op_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int lfp_res_w(input int exp_w, input int man_w);
    return 2 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/lfp_lane_core.sv
// One multiplier lane, purely combinational: stage-1 log-domain add and stage-2 antilog correction.
// No latency or backpressure of its own; the parent owns the registers between the two halves.
module lfp_lane_core
  import lfp_pkg::*;
#(
  parameter int  EXP_W = 4,
  parameter int  MAN_W = 3,
  localparam int OW    = lfp_op_w(EXP_W, MAN_W),
  localparam int RW    = lfp_res_w(EXP_W, MAN_W),
  localparam int YW    = EXP_W + MAN_W + 1
) (
  input  logic [OW-1:0] i_a,
  input  logic [OW-1:0] i_b,
  output logic          o_sy,
  output logic          o_za,
  output logic [YW-1:0] o_ya,
  input  logic          i_s1_sy,
  input  logic          i_s1_za,
  input  logic [YW-1:0] i_s1_ya,
  output logic [RW-1:0] o_y
);

  localparam int N = 1 << MAN_W;
  localparam logic [N-1:0] LOG_V = VLOG_TAB[MAN_W][N-1:0];
  localparam logic [N-1:0] EXP_V = VEXP_TAB[MAN_W][N-1:0];

  logic             w_vlog_a;
  logic             w_vlog_b;
  logic             w_vexp;
  logic [MAN_W-1:0] w_man;

  assign w_vlog_a = LOG_V[i_a[MAN_W-1:0]];
  assign w_vlog_b = LOG_V[i_b[MAN_W-1:0]];

  assign o_sy = i_a[OW-1] ^ i_b[OW-1];
  assign o_za = (i_a[OW-2:MAN_W] == '0) | (i_b[OW-2:MAN_W] == '0);
  // Packed {exp,man} add lets the mantissa carry ripple straight into the exponent.
  assign o_ya = {1'b0, i_a[OW-2:0]} + {1'b0, i_b[OW-2:0]} + YW'(w_vlog_a) + YW'(w_vlog_b);

  assign w_vexp = EXP_V[i_s1_ya[MAN_W-1:0]];
  assign w_man  = i_s1_ya[MAN_W-1:0] - MAN_W'(w_vexp);
  assign o_y    = i_s1_za ? '0 : {i_s1_sy, i_s1_ya[YW-1:MAN_W], w_man};

endmodule

// File: rtl/lfp_mult_pipe.sv
// Multi-lane LFP multiplier, two register stages, 2-cycle latency at 1 beat/cycle.
// Valid/ready: in_ready is combinational from out_ready; stalled stages hold data and valid.
module lfp_mult_pipe
  import lfp_pkg::*;
#(
  parameter int  EXP_W = 4,
  parameter int  MAN_W = 3,
  parameter int  LANES = 4,
  parameter int  TAG_W = 4,
  localparam int OW    = lfp_op_w(EXP_W, MAN_W),
  localparam int RW    = lfp_res_w(EXP_W, MAN_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*OW-1:0] in_a,
  input  logic [LANES*OW-1:0] in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*RW-1:0] out_y,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int YW = EXP_W + MAN_W + 1;

  if (MAN_W < MAN_W_MIN || MAN_W > MAN_W_MAX) begin : g_bad_man_w
    $error("lfp_mult_pipe: MAN_W must be in 2..4");
  end

  logic                r_s1_vld;
  logic [TAG_W-1:0]    r_s1_tag;
  logic [LANES-1:0]    r_s1_sy;
  logic [LANES-1:0]    r_s1_za;
  logic [LANES*YW-1:0] r_s1_ya;
  logic                r_s2_vld;
  logic [TAG_W-1:0]    r_s2_tag;
  logic [LANES*RW-1:0] r_s2_y;

  logic                w_s1_en;
  logic                w_s2_en;
  logic [LANES-1:0]    w_sy;
  logic [LANES-1:0]    w_za;
  logic [LANES*YW-1:0] w_ya;
  logic [LANES*RW-1:0] w_y;

  assign w_s2_en = ~r_s2_vld | out_ready;
  assign w_s1_en = ~r_s1_vld | w_s2_en;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lfp_lane_core #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
    ) u_core (
      .i_a     (in_a[k*OW +: OW]),
      .i_b     (in_b[k*OW +: OW]),
      .o_sy    (w_sy[k]),
      .o_za    (w_za[k]),
      .o_ya    (w_ya[k*YW +: YW]),
      .i_s1_sy (r_s1_sy[k]),
      .i_s1_za (r_s1_za[k]),
      .i_s1_ya (r_s1_ya[k*YW +: YW]),
      .o_y     (w_y[k*RW +: RW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_tag <= '0;
      r_s1_sy  <= '0;
      r_s1_za  <= '0;
      r_s1_ya  <= '0;
      r_s2_vld <= 1'b0;
      r_s2_tag <= '0;
      r_s2_y   <= '0;
    end else begin
      if (w_s1_en) begin
        r_s1_vld <= in_valid;
        r_s1_tag <= in_tag;
        r_s1_sy  <= w_sy;
        r_s1_za  <= w_za;
        r_s1_ya  <= w_ya;
      end
      if (w_s2_en) begin
        r_s2_vld <= r_s1_vld;
        r_s2_tag <= r_s1_tag;
        r_s2_y   <= w_y;
      end
    end
  end

  assign in_ready  = w_s1_en;
  assign out_valid = r_s2_vld;
  assign out_y     = r_s2_y;
  assign out_tag   = r_s2_tag;

endmodule

// File: tb/tb_lfp_mult_pipe.sv
// Directed and random stimulus for lfp_mult_pipe at default parameters, checked against a queued reference.
module tb_lfp_mult_pipe;

  typedef struct packed {
    logic [3:0]  tag;
    logic [35:0] y;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_y;
  logic [3:0]  out_tag;

  exp_t sb_q[$];
  exp_t cur_exp;
  bit   last_acc;
  int   n_vec;
  int   n_err;

  lfp_mult_pipe #(
    .EXP_W (4),
    .MAN_W (3),
    .LANES (4),
    .TAG_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  function automatic logic [8:0] lane_model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ya;
    logic [2:0] mf;
    logic       vl_a;
    logic       vl_b;
    logic       ve;
    if (a[6:3] == 4'd0 || b[6:3] == 4'd0) return 9'd0;
    vl_a = a[2:0] inside {3'd2, 3'd3, 3'd4, 3'd5};
    vl_b = b[2:0] inside {3'd2, 3'd3, 3'd4, 3'd5};
    ya   = {1'b0, a[6:0]} + {1'b0, b[6:0]} + 8'(vl_a) + 8'(vl_b);
    ve   = ya[2:0] inside {3'd3, 3'd4, 3'd5, 3'd6};
    mf   = ya[2:0] - 3'(ve);
    return {a[7] ^ b[7], ya[7:3], mf};
  endfunction

  function automatic logic [35:0] model_vec(input logic [31:0] a, input logic [31:0] b);
    logic [35:0] y;
    for (int k = 0; k < 4; k++) y[k*9 +: 9] = lane_model(a[k*8 +: 8], b[k*8 +: 8]);
    return y;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag, input logic [35:0] y);
    in_a        = a;
    in_b        = b;
    in_tag      = tag;
    in_valid    = 1'b1;
    cur_exp.tag = tag;
    cur_exp.y   = y;
  endtask

  task automatic rand_beat(input logic [3:0] tag);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = $urandom;
    drive_beat(a, b, tag, model_vec(a, b));
  endtask

  task automatic tick();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        for (int k = 0; k < 4; k++)
          check($sformatf("out_y_lane%0d", k), 64'(out_y[k*9 +: 9]), 64'(e.y[k*9 +: 9]));
        check("out_tag", 64'(out_tag), 64'(e.tag));
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) sb_q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12 && sb_q.size() > 0; i++) tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic send_lat(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [35:0] y);
    out_ready = 1'b1;
    drive_beat(a, b, tag, y);
    tick();
    in_valid = 1'b0;
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [35:0] y;
    int          t;
    int          cyc;
    int          sent;

    n_vec     = 0;
    n_err     = 0;
    last_acc  = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    cur_exp   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // lane0 plain, lane1 log corrections, lane2 sign, lane3 zero exponent
    send_lat({8'h05, 8'hB8, 8'h3A, 8'h38}, {8'h3F, 8'h38, 8'h3A, 8'h38}, 4'h5,
             {9'h000, 9'h170, 9'h075, 9'h070});

    // mantissa carry into exponent on lane 0
    a = $urandom;
    b = $urandom;
    a[7:0] = 8'h3F;
    b[7:0] = 8'h09;
    y = model_vec(a, b);
    y[8:0] = 9'h048;
    send_lat(a, b, 4'h9, y);

    for (int i = 0; i < 8; i++) begin
      rand_beat(4'(i));
      tick();
    end
    drain();

    sent = 0;
    rand_beat(4'h0);
    for (int i = 0; i < 60 && sent < 10; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (last_acc) begin
        sent++;
        rand_beat(4'(sent));
      end
    end
    check("rand_ready_sent", 64'(sent), 64'd10);
    drain();

    // back-to-back tags 1..6 with a 3-cycle output stall once both stages hold data
    t   = 1;
    cyc = 0;
    rand_beat(4'(t));
    while (t <= 6 && cyc < 40) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      if (!out_ready) begin
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_tag_hold", 64'(out_tag), 64'(sb_q[0].tag));
        check("bp_out_y_hold", 64'(out_y), 64'(sb_q[0].y));
      end
      tick();
      if (last_acc) begin
        t++;
        if (t <= 6) rand_beat(4'(t));
      end
      cyc++;
    end
    check("bp_all_sent", 64'(t), 64'd7);
    drain();

    // reset with both stages full discards them
    out_ready = 1'b0;
    drive_beat({4{8'h3A}}, {4{8'h3A}}, 4'hA, {4{9'h075}});
    tick();
    drive_beat({4{8'hB8}}, {4{8'h38}}, 4'hB, {4{9'h170}});
    tick();
    in_valid = 1'b0;
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_y", 64'(out_y), 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);

    send_lat({8'h3F, 8'h05, 8'hB8, 8'h38}, {8'h09, 8'h3F, 8'h38, 8'h38}, 4'hC,
             {9'h048, 9'h000, 9'h170, 9'h070});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
